// File: rtl/ika9958_vram_arb_pkg.sv
// ika9958_vram_arb_pkg.sv
// Shared mnemonics for the VRAM arbiter:
//   ArbState_t       - arbiter FSM states (IDLE, BUSY, DONE)
//   OWN_CPU/OWN_CMD  - encoding of mem_owner and of the round-robin priority bit
`timescale 1ns/1ps
package IKA9958_mnemonics;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ArbState_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_CMD = 1'b1;

endpackage

// File: rtl/ika9958_vram_arb_sel.sv
// ika9958_vram_arb_sel.sv
// Combinational eligibility mask and winner select for the VRAM arbiter.
// Optional macro IKA9958_ARB_RR_EN: contention is resolved by i_prio
// (round robin); otherwise the CPU always wins a contended slot.
// Ports:
//   i_cpu_req/i_cmd_req    level requests
//   i_cpu_mask/i_cmd_mask  suppress a requester for this tick
//   i_prio                 (RR only) owner that wins the next contention
//   o_any                  at least one eligible request
//   o_contend              both requests eligible
//   o_owner                winning owner (OWN_CPU/OWN_CMD)
`timescale 1ns/1ps
module ika9958_vram_arb_sel
    import IKA9958_mnemonics::*;
(
    input  logic i_cpu_req,
    input  logic i_cmd_req,
    input  logic i_cpu_mask,
    input  logic i_cmd_mask,
`ifdef IKA9958_ARB_RR_EN
    input  logic i_prio,
`endif
    output logic o_any,
    output logic o_contend,
    output logic o_owner
);

    logic w_cpu_el;
    logic w_cmd_el;

    assign w_cpu_el  = i_cpu_req & ~i_cpu_mask;
    assign w_cmd_el  = i_cmd_req & ~i_cmd_mask;
    assign o_any     = w_cpu_el | w_cmd_el;
    assign o_contend = w_cpu_el & w_cmd_el;

`ifdef IKA9958_ARB_RR_EN
    assign o_owner = o_contend ? i_prio : (w_cmd_el ? OWN_CMD : OWN_CPU);
`else
    assign o_owner = (w_cmd_el && !w_cpu_el) ? OWN_CMD : OWN_CPU;
`endif

endmodule

// File: rtl/ika9958_vram_arb.sv
// ika9958_vram_arb.sv
// VRAM arbiter between the CPU port and the command engine. A request is
// granted only in a free (non-refresh) bpc slot; the winner's access is
// latched onto mem_*, started with a one-tick mem_start, and completed with a
// one-tick ack plus read data. A BUSY watchdog forces completion after TMO
// ticks with 8'hFF read data and a sticky tmo_flag.
// Optional macro IKA9958_ARB_RR_EN: round-robin arbitration on contention.
// Ports:
//   phiA, RST_async_n, phiL_NCEN   clock, async active-low reset, tick enable
//   slot_free, slot_refresh        slot schedule from the memory PLA
//   cpu_*/cmd_*                    requester ports (req/we/addr/wdata in,
//                                  ack/rdata out)
//   mem_*                          DRAM sequencer side (start/we/addr/wdata/
//                                  owner out, done/rdata in)
//   tmo_flag                       sticky watchdog error
`timescale 1ns/1ps
module ika9958_vram_arb
    import IKA9958_mnemonics::*;
#(
    parameter int AW  = 17,
    parameter int TMO = 15
) (
    input  logic          phiA,
    input  logic          RST_async_n,
    input  logic          phiL_NCEN,
    input  logic          slot_free,
    input  logic          slot_refresh,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    input  logic          cmd_req,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_wdata,
    output logic          cmd_ack,
    output logic [7:0]    cmd_rdata,
    output logic          mem_start,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_done,
    input  logic [7:0]    mem_rdata,
    output logic          mem_owner,
    output logic          tmo_flag
);

    // r_cnt holds the BUSY ticks already spent, so the current BUSY tick is
    // the TMO-th one when r_cnt equals TMO-1.
    localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

    ArbState_t     r_state;
    ArbState_t     w_state_nxt;
    logic          r_start;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic          r_owner;
    logic          r_cpu_ack;
    logic          r_cmd_ack;
    logic [7:0]    r_cpu_rd;
    logic [7:0]    r_cmd_rd;
    logic          r_tmo;
    logic [3:0]    r_cnt;

    logic          w_any;
    logic          w_contend;
    logic          w_owner;
    logic          w_grant;
    logic          w_fin;
    logic          w_tmo_hit;
    logic [7:0]    w_rd_val;

`ifdef IKA9958_ARB_RR_EN
    logic          r_prio;
`endif

    // A requester whose ack is showing this tick may not have dropped req
    // yet; keep it out of the race so it cannot be granted twice.
    ika9958_vram_arb_sel u_sel (
        .i_cpu_req  (cpu_req),
        .i_cmd_req  (cmd_req),
        .i_cpu_mask (r_cpu_ack),
        .i_cmd_mask (r_cmd_ack),
`ifdef IKA9958_ARB_RR_EN
        .i_prio     (r_prio),
`endif
        .o_any      (w_any),
        .o_contend  (w_contend),
        .o_owner    (w_owner)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fin       = 1'b0;
        w_tmo_hit   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (slot_free && !slot_refresh && w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // mem_done wins a tie with the watchdog
                if (mem_done) begin
                    w_fin       = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt == TMO_LAST) begin
                    w_fin       = 1'b1;
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rd_val = w_tmo_hit ? 8'hFF : mem_rdata;

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            r_state <= IDLE;
        end else if (phiL_NCEN) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            r_start   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 8'h00;
            r_owner   <= OWN_CPU;
            r_cpu_ack <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_cpu_rd  <= 8'h00;
            r_cmd_rd  <= 8'h00;
            r_tmo     <= 1'b0;
            r_cnt     <= 4'd0;
`ifdef IKA9958_ARB_RR_EN
            r_prio    <= OWN_CPU;
`endif
        end else if (phiL_NCEN) begin
            r_start   <= w_grant;
            r_cpu_ack <= w_fin && (r_owner == OWN_CPU);
            r_cmd_ack <= w_fin && (r_owner == OWN_CMD);

            if (w_grant) begin
                r_owner <= w_owner;
                r_we    <= (w_owner == OWN_CMD) ? cmd_we    : cpu_we;
                r_addr  <= (w_owner == OWN_CMD) ? cmd_addr  : cpu_addr;
                r_wdata <= (w_owner == OWN_CMD) ? cmd_wdata : cpu_wdata;
                r_cnt   <= 4'd0;
            end else if (r_state == BUSY && !w_fin) begin
                r_cnt   <= r_cnt + 4'd1;
            end

            if (w_fin && !r_we) begin
                if (r_owner == OWN_CMD) r_cmd_rd <= w_rd_val;
                else                    r_cpu_rd <= w_rd_val;
            end

            if (w_tmo_hit) r_tmo <= 1'b1;

`ifdef IKA9958_ARB_RR_EN
            // hand the next contention to the requester that just lost
            if (w_grant && w_contend) r_prio <= ~w_owner;
`endif
        end
    end

    assign mem_start = r_start;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_owner = r_owner;
    assign cpu_ack   = r_cpu_ack;
    assign cmd_ack   = r_cmd_ack;
    assign cpu_rdata = r_cpu_rd;
    assign cmd_rdata = r_cmd_rd;
    assign tmo_flag  = r_tmo;

endmodule

// File: tb/tb_ika9958_vram_arb.sv
`timescale 1ns/1ps
module tb_ika9958_vram_arb;

    localparam int AW  = 17;
    localparam int TMO = 15;

    logic          phiA = 1'b0;
    logic          RST_async_n = 1'b0;
    logic          phiL_NCEN = 1'b1;
    logic          slot_free = 1'b0;
    logic          slot_refresh = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = 8'h00;
    logic          cmd_req = 1'b0, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_wdata = 8'h00;
    logic          mem_done = 1'b0;
    logic [7:0]    mem_rdata = 8'h00;
    logic          cpu_ack, cmd_ack, mem_start, mem_we, mem_owner, tmo_flag;
    logic [7:0]    cpu_rdata, cmd_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    ika9958_vram_arb #(.AW(AW), .TMO(TMO)) dut (
        .phiA(phiA), .RST_async_n(RST_async_n), .phiL_NCEN(phiL_NCEN),
        .slot_free(slot_free), .slot_refresh(slot_refresh),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_owner(mem_owner), .tmo_flag(tmo_flag)
    );

    always #5 phiA = ~phiA;

    int n_cmp = 0;
    int n_bad = 0;
    bit half  = 1'b0;

    // expected outputs for the tick currently visible
    bit            e_start, e_cpu_ack, e_cmd_ack, e_owner, e_we, e_tmo;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wdata, e_cpu_rd, e_cmd_rd;
    bit            prio;   // owner that wins the next contention (RR build only)

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_start = 0; e_cpu_ack = 0; e_cmd_ack = 0; e_owner = 0; e_we = 0; e_tmo = 0;
        e_addr = '0; e_wdata = 8'h00; e_cpu_rd = 8'h00; e_cmd_rd = 8'h00; prio = 0;
    endtask

    task automatic check_all(input string t);
        chk({t, ":start"},   32'(mem_start), 32'(e_start));
        chk({t, ":cpu_ack"}, 32'(cpu_ack),   32'(e_cpu_ack));
        chk({t, ":cmd_ack"}, 32'(cmd_ack),   32'(e_cmd_ack));
        chk({t, ":owner"},   32'(mem_owner), 32'(e_owner));
        chk({t, ":we"},      32'(mem_we),    32'(e_we));
        chk({t, ":addr"},    32'(mem_addr),  32'(e_addr));
        chk({t, ":wdata"},   32'(mem_wdata), 32'(e_wdata));
        chk({t, ":cpu_rd"},  32'(cpu_rdata), 32'(e_cpu_rd));
        chk({t, ":cmd_rd"},  32'(cmd_rdata), 32'(e_cmd_rd));
        chk({t, ":tmo"},     32'(tmo_flag),  32'(e_tmo));
    endtask

    // One enabled tick; in half-rate mode a disabled edge follows, across
    // which every output must hold.
    task automatic tick();
        phiL_NCEN = 1'b1;
        @(posedge phiA); @(negedge phiA);
        check_all("tick");
        if (half) begin
            phiL_NCEN = 1'b0;
            @(posedge phiA); @(negedge phiA);
            check_all("hold");
            phiL_NCEN = 1'b1;
        end
    endtask

    // One arbitration round. rc/rm: 1 raise request, 0 leave as is, -1 random.
    // lat: BUSY tick on which mem_done arrives (0 = random, >TMO = withheld).
    // rdv: read data (-1 = random). refr: refresh collision first (-1 random).
    task automatic run_txn(input int rc, input int rm, input int lat, input int rdv, input int refr);
        bit w, contend;
        int n;
        if (!cpu_req) begin
            cpu_req = (rc < 0) ? 1'($urandom_range(0, 1)) : 1'(rc);
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
        end
        if (!cmd_req) begin
            cmd_req = (rm < 0) ? 1'($urandom_range(0, 1)) : 1'(rm);
            cmd_we = 1'($urandom_range(0, 1)); cmd_addr = AW'($urandom); cmd_wdata = 8'($urandom);
        end
        if (lat == 0) lat = $urandom_range(2, TMO + 2);
        // idle gap; stray mem_done outside BUSY must do nothing
        repeat ($urandom_range(0, 2)) begin
            mem_done = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
            tick();
        end
        mem_done = 0;
        if (!cpu_req && !cmd_req) begin
            slot_free = 1; tick(); slot_free = 0;
            return;
        end
        if (refr > 0 || (refr < 0 && $urandom_range(0, 3) == 0)) begin
            slot_free = 1; slot_refresh = 1; tick(); slot_refresh = 0;
        end
        contend = cpu_req && cmd_req;
        w = contend ? prio : cmd_req;
`ifdef IKA9958_ARB_RR_EN
        if (contend) prio = ~w;
`endif
        e_start = 1; e_owner = w;
        e_we    = w ? cmd_we    : cpu_we;
        e_addr  = w ? cmd_addr  : cpu_addr;
        e_wdata = w ? cmd_wdata : cpu_wdata;
        slot_free = 1; tick();
        e_start = 0;
        n = (lat <= TMO) ? lat : TMO;
        for (int j = 1; j <= n; j++) begin
            mem_done  = (j == lat);
            mem_rdata = (rdv < 0) ? 8'($urandom) : 8'(rdv);
            slot_free = 1'($urandom_range(0, 1));   // ignored while BUSY
            if (j == n) begin
                if (w) e_cmd_ack = 1; else e_cpu_ack = 1;
                if (!e_we) begin
                    if (w) e_cmd_rd = (lat <= TMO) ? mem_rdata : 8'hFF;
                    else   e_cpu_rd = (lat <= TMO) ? mem_rdata : 8'hFF;
                end
                if (lat > TMO) e_tmo = 1;
            end
            tick();
        end
        // ack tick: winner drops req; a slot here is lost
        if (w) cmd_req = 0; else cpu_req = 0;
        mem_done  = 1'($urandom_range(0, 1));
        slot_free = 1'($urandom_range(0, 1));
        e_cpu_ack = 0; e_cmd_ack = 0;
        tick();
        slot_free = 0; mem_done = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge phiA);
        check_all("reset");
        RST_async_n = 1'b1;
        tick();

        // CPU read of 17'h1_2345, data A5, done 3 ticks after the slot
        cpu_req = 1; cpu_we = 0; cpu_addr = 17'h1_2345; cpu_wdata = 8'h3C;
        run_txn(1, 0, 3, 8'hA5, 0);

        // contention over three slots, CPU re-requesting once
        run_txn(1, 1, 2, -1, 0);
        run_txn(1, 0, 2, -1, 0);
        run_txn(0, 0, 2, -1, 0);

        // slot collides with refresh, then a clean slot
        run_txn(1, 0, 4, -1, 1);

        // watchdog: done withheld on a read
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'($urandom);
        run_txn(1, 0, TMO + 3, -1, 0);
        // done exactly on the watchdog tick is a normal completion
        cmd_req = 1; cmd_we = 0; cmd_addr = AW'($urandom);
        run_txn(0, 1, TMO, 8'h5A, 0);

        // half-rate enable, CPU read
        half = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 17'h1_2345;
        run_txn(1, 0, 3, 8'hA5, 0);
        half = 0;

        for (int k = 0; k < 40; k++) run_txn(-1, -1, 0, -1, -1);

        // reset during BUSY aborts the access
        cpu_req = 1; cpu_we = 0; cpu_addr = AW'($urandom); cmd_req = 0;
        e_start = 1; e_owner = 0; e_we = 0; e_addr = cpu_addr; e_wdata = cpu_wdata;
        slot_free = 1; tick(); slot_free = 0;
        e_start = 0; tick();
        #2 RST_async_n = 1'b0;
        #1 model_reset();
        check_all("rst_busy");
        cpu_req = 0; cmd_req = 0;
        @(negedge phiA); RST_async_n = 1'b1;
        mem_done = 1; mem_rdata = 8'h77; tick();
        mem_done = 0; tick();

        for (int k = 0; k < 10; k++) run_txn(-1, -1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
